// File: rtl/riscv_alu_unit.sv
`default_nettype none
// ============================================================================
// Module      : riscv_alu_unit
// Description : RV32I execute-stage ALU with its own control decoder.
//               opcode / funct3 / instr[30] are decoded into a 4-bit ALUop,
//               which selects one of the integer operations on A and B.
//               Out is the zero-latency combinational result for same-cycle
//               consumers; Out_q is the same value captured for the pipeline
//               register.
// Ports       : Clock            in   1  system clock, rising edge
//               Reset            in   1  synchronous, active-high; clears Out_q
//               opcode           in   7  instr[6:0]
//               funct            in   3  instr[14:12]
//               add_rshift_type  in   1  instr[30]: SUB/ADD and SRA/SRL select
//               A                in  32  operand A (rs1 or PC)
//               B                in  32  operand B (rs2 or immediate)
//               ALUop            out  4  decoded operation (combinational)
//               Out              out 32  ALU result (combinational)
//               Out_q            out 32  Out registered on Clock
// Revision    : 1.0  initial release
// ============================================================================
module riscv_alu_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct,
  input  logic        add_rshift_type,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [3:0]  ALUop,
  output logic [31:0] Out,
  output logic [31:0] Out_q
);

  // --------------------------------------------------------------------------
  // ALU operation encoding
  // --------------------------------------------------------------------------
  localparam logic [3:0] C_ALU_ADD    = 4'd0;
  localparam logic [3:0] C_ALU_SUB    = 4'd1;
  localparam logic [3:0] C_ALU_AND    = 4'd2;
  localparam logic [3:0] C_ALU_OR     = 4'd3;
  localparam logic [3:0] C_ALU_XOR    = 4'd4;
  localparam logic [3:0] C_ALU_SLT    = 4'd5;
  localparam logic [3:0] C_ALU_SLTU   = 4'd6;
  localparam logic [3:0] C_ALU_SLL    = 4'd7;
  localparam logic [3:0] C_ALU_SRL    = 4'd8;
  localparam logic [3:0] C_ALU_SRA    = 4'd9;
  localparam logic [3:0] C_ALU_COPY_B = 4'd10;
  localparam logic [3:0] C_ALU_XXX    = 4'd15;

  // --------------------------------------------------------------------------
  // RV32I major opcodes
  // --------------------------------------------------------------------------
  localparam logic [6:0] C_OPC_LUI       = 7'b0110111;
  localparam logic [6:0] C_OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] C_OPC_JAL       = 7'b1101111;
  localparam logic [6:0] C_OPC_JALR      = 7'b1100111;
  localparam logic [6:0] C_OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] C_OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] C_OPC_STORE     = 7'b0100011;
  localparam logic [6:0] C_OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] C_OPC_ARI_RTYPE = 7'b0110011;

  // funct3 values of the arithmetic group
  localparam logic [2:0] C_F3_ADD  = 3'b000;
  localparam logic [2:0] C_F3_SLL  = 3'b001;
  localparam logic [2:0] C_F3_SLT  = 3'b010;
  localparam logic [2:0] C_F3_SLTU = 3'b011;
  localparam logic [2:0] C_F3_XOR  = 3'b100;
  localparam logic [2:0] C_F3_SR   = 3'b101;
  localparam logic [2:0] C_F3_OR   = 3'b110;
  localparam logic [2:0] C_F3_AND  = 3'b111;

  logic [3:0]  w_arith_op;
  logic [3:0]  w_alu_op;
  logic [4:0]  w_shamt;
  logic        w_lt_signed;
  logic        w_lt_unsigned;
  logic [31:0] w_result;
  logic [31:0] r_out_q;

  // --------------------------------------------------------------------------
  // Arithmetic-group decode, shared by R-type and I-type. funct3=000 with
  // instr[30] set means SUB, but only for R-type: in I-type encodings that
  // bit belongs to the immediate, so ADDI must not be turned into a subtract.
  // --------------------------------------------------------------------------
  always_comb begin
    w_arith_op = C_ALU_XXX;
    case (funct)
      C_F3_ADD: begin
        if ((opcode == C_OPC_ARI_RTYPE) && add_rshift_type) begin
          w_arith_op = C_ALU_SUB;
        end else begin
          w_arith_op = C_ALU_ADD;
        end
      end
      C_F3_SLL:  w_arith_op = C_ALU_SLL;
      C_F3_SLT:  w_arith_op = C_ALU_SLT;
      C_F3_SLTU: w_arith_op = C_ALU_SLTU;
      C_F3_XOR:  w_arith_op = C_ALU_XOR;
      C_F3_SR:   w_arith_op = add_rshift_type ? C_ALU_SRA : C_ALU_SRL;
      C_F3_OR:   w_arith_op = C_ALU_OR;
      C_F3_AND:  w_arith_op = C_ALU_AND;
      default:   w_arith_op = C_ALU_XXX;
    endcase
  end

  // --------------------------------------------------------------------------
  // Top-level opcode decode. Address-forming instructions (PC+imm, rs1+imm,
  // branch target) all reduce to ADD; funct and instr[30] are don't-cares.
  // --------------------------------------------------------------------------
  always_comb begin
    w_alu_op = C_ALU_XXX;
    case (opcode)
      C_OPC_LUI:       w_alu_op = C_ALU_COPY_B;
      C_OPC_AUIPC,
      C_OPC_JAL,
      C_OPC_JALR,
      C_OPC_BRANCH,
      C_OPC_LOAD,
      C_OPC_STORE:     w_alu_op = C_ALU_ADD;
      C_OPC_ARI_ITYPE,
      C_OPC_ARI_RTYPE: w_alu_op = w_arith_op;
      default:         w_alu_op = C_ALU_XXX;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath. Shift amount is B[4:0] only; upper bits of B are ignored so an
  // I-type immediate carrying funct7 in imm[11:5] shifts correctly.
  // --------------------------------------------------------------------------
  assign w_shamt       = B[4:0];
  assign w_lt_signed   = $signed(A) < $signed(B);
  assign w_lt_unsigned = A < B;

  always_comb begin
    w_result = 32'h0000_0000;
    case (w_alu_op)
      C_ALU_ADD:    w_result = A + B;
      C_ALU_SUB:    w_result = A - B;
      C_ALU_AND:    w_result = A & B;
      C_ALU_OR:     w_result = A | B;
      C_ALU_XOR:    w_result = A ^ B;
      C_ALU_SLT:    w_result = {31'b0, w_lt_signed};
      C_ALU_SLTU:   w_result = {31'b0, w_lt_unsigned};
      C_ALU_SLL:    w_result = A << w_shamt;
      C_ALU_SRL:    w_result = A >> w_shamt;
      C_ALU_SRA:    w_result = $unsigned($signed(A) >>> w_shamt);
      C_ALU_COPY_B: w_result = B;
      default:      w_result = 32'h0000_0000;
    endcase
  end

  // --------------------------------------------------------------------------
  // Pipeline register: the only state in the block. Reset wins over any
  // combinational activity on the same edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_out_q <= 32'h0000_0000;
    end else begin
      r_out_q <= w_result;
    end
  end

  assign ALUop = w_alu_op;
  assign Out   = w_result;
  assign Out_q = r_out_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_alu_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_alu_unit
// Description : Directed, table-driven bench for riscv_alu_unit. Each table
//               record holds the instruction fields, operands and the
//               hand-computed ALUop / result; the combinational outputs are
//               compared, then the registered copy after the next edge.
//               A hand-written sequence covers Reset behaviour of Out_q.
// Revision    : 1.0  initial release
// ============================================================================
module tb_riscv_alu_unit;

  typedef struct {
    string       name;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        ars;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  exp_op;
    logic [31:0] exp_out;
  } vec_t;

  localparam int C_MAX_VEC = 40;

  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_R   = 7'b0110011;

  logic        Clock;
  logic        Reset;
  logic [6:0]  opcode;
  logic [2:0]  funct;
  logic        add_rshift_type;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUop;
  logic [31:0] Out;
  logic [31:0] Out_q;

  vec_t vecs[C_MAX_VEC];
  int   n_vec;
  int   errors;
  int   checks;

  riscv_alu_unit dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .opcode          (opcode),
    .funct           (funct),
    .add_rshift_type (add_rshift_type),
    .A               (A),
    .B               (B),
    .ALUop           (ALUop),
    .Out             (Out),
    .Out_q           (Out_q)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic add_vec(input string name, input logic [6:0] opc, input logic [2:0] f3,
                         input logic ars, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] exp_op, input logic [31:0] exp_out);
    vecs[n_vec] = '{name, opc, f3, ars, a, b, exp_op, exp_out};
    n_vec++;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic ars,
                       input logic [31:0] a, input logic [31:0] b);
    opcode          = opc;
    funct           = f3;
    add_rshift_type = ars;
    A               = a;
    B               = b;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    n_vec  = 0;
    Reset  = 1'b1;
    drive(7'd0, 3'd0, 1'b0, 32'h0, 32'h0);

    // name, opcode, funct3, instr30, A, B, ALUop, Out
    add_vec("lui",        OP_LUI, 3'b101, 1'b1, 32'h12345678, 32'hFFFF8123, 4'd10, 32'hFFFF8123);
    add_vec("lui_f0",     OP_LUI, 3'b000, 1'b0, 32'h12345678, 32'hFFFF8123, 4'd10, 32'hFFFF8123);
    add_vec("r_add",      OP_R,   3'b000, 1'b0, 32'h80000000, 32'h00000001, 4'd0,  32'h80000001);
    add_vec("r_sub",      OP_R,   3'b000, 1'b1, 32'h80000000, 32'h00000001, 4'd1,  32'h7FFFFFFF);
    add_vec("i_add_ars",  OP_I,   3'b000, 1'b1, 32'h80000000, 32'h00000001, 4'd0,  32'h80000001);
    add_vec("store",      OP_ST,  3'b010, 1'b1, 32'h80000000, 32'h00000001, 4'd0,  32'h80000001);
    add_vec("r_slt",      OP_R,   3'b010, 1'b0, 32'h80000000, 32'h00000001, 4'd5,  32'h00000001);
    add_vec("r_sltu",     OP_R,   3'b011, 1'b0, 32'h80000000, 32'h00000001, 4'd6,  32'h00000000);
    add_vec("i_slt_neg",  OP_I,   3'b010, 1'b0, 32'hFFFFFFFF, 32'hFFFF8000, 4'd5,  32'h00000000);
    add_vec("i_sltu_big", OP_I,   3'b011, 1'b1, 32'hFFFFFFFF, 32'hFFFF8000, 4'd6,  32'h00000000);
    add_vec("r_slt_rev",  OP_R,   3'b010, 1'b1, 32'hFFFF8000, 32'hFFFFFFFF, 4'd5,  32'h00000001);
    add_vec("r_sll",      OP_R,   3'b001, 1'b0, 32'h80000010, 32'hFFFF8024, 4'd7,  32'h00000100);
    add_vec("r_srl",      OP_R,   3'b101, 1'b0, 32'h80000010, 32'hFFFF8024, 4'd8,  32'h08000001);
    add_vec("r_sra",      OP_R,   3'b101, 1'b1, 32'h80000010, 32'hFFFF8024, 4'd9,  32'hF8000001);
    add_vec("i_sll",      OP_I,   3'b001, 1'b1, 32'h80000010, 32'hFFFF8024, 4'd7,  32'h00000100);
    add_vec("i_srl",      OP_I,   3'b101, 1'b0, 32'h80000010, 32'hFFFF8024, 4'd8,  32'h08000001);
    add_vec("i_sra",      OP_I,   3'b101, 1'b1, 32'h80000010, 32'hFFFF8024, 4'd9,  32'hF8000001);
    add_vec("r_sra_pos",  OP_R,   3'b101, 1'b1, 32'h70000000, 32'h0000001F, 4'd9,  32'h00000000);
    add_vec("bad_opc",    7'b1111111, 3'b000, 1'b0, 32'h12345678, 32'h9ABCDEF0, 4'd15, 32'h00000000);
    add_vec("zero_opc",   7'b0000000, 3'b111, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd15, 32'h00000000);
    add_vec("r_and",      OP_R,   3'b111, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 4'd2,  32'hF000F000);
    add_vec("i_or",       OP_I,   3'b110, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 4'd3,  32'hFFF0FFF0);
    add_vec("r_xor_ars",  OP_R,   3'b100, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 4'd4,  32'h0FF00FF0);
    add_vec("auipc",      OP_AUI, 3'b011, 1'b1, 32'h00400000, 32'h12345000, 4'd0,  32'h12745000);
    add_vec("jal",        OP_JAL, 3'b000, 1'b1, 32'h00001000, 32'h00000004, 4'd0,  32'h00001004);
    add_vec("jalr",       OP_JLR, 3'b000, 1'b0, 32'h00000008, 32'h00000008, 4'd0,  32'h00000010);
    add_vec("branch",     OP_BR,  3'b001, 1'b1, 32'h00000005, 32'hFFFFFFFF, 4'd0,  32'h00000004);
    add_vec("load",       OP_LD,  3'b100, 1'b0, 32'h00000100, 32'hFFFFFFFC, 4'd0,  32'h000000FC);
    add_vec("r_add_wrap", OP_R,   3'b000, 1'b0, 32'hFFFFFFFF, 32'h00000002, 4'd0,  32'h00000001);

    // Leave reset after two edges with a benign input pattern.
    @(posedge Clock);
    @(posedge Clock);
    #1;
    check32("out_q_reset", Out_q, 32'h0);
    @(negedge Clock);
    Reset = 1'b0;

    // Table: combinational check mid-cycle, registered check after the edge.
    for (int i = 0; i < n_vec; i++) begin
      drive(vecs[i].opc, vecs[i].f3, vecs[i].ars, vecs[i].a, vecs[i].b);
      #1;
      check4({vecs[i].name, "_op"}, ALUop, vecs[i].exp_op);
      check32({vecs[i].name, "_out"}, Out, vecs[i].exp_out);
      @(posedge Clock);
      #1;
      check32({vecs[i].name, "_q"}, Out_q, vecs[i].exp_out);
      @(negedge Clock);
    end

    // Reset sequence with Out held at 0xDEADBEEF via LUI.
    drive(OP_LUI, 3'b000, 1'b0, 32'h0, 32'hDEADBEEF);
    Reset = 1'b1;
    #1;
    check32("rst_out_comb", Out, 32'hDEADBEEF);
    check4("rst_op_comb", ALUop, 4'd10);
    @(posedge Clock);
    #1;
    check32("rst_edge1_q", Out_q, 32'h0);
    @(posedge Clock);
    #1;
    check32("rst_edge2_q", Out_q, 32'h0);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    check32("rel_before_edge_q", Out_q, 32'h0);
    @(posedge Clock);
    #1;
    check32("rel_edge_q", Out_q, 32'hDEADBEEF);
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    check32("reassert_hold_q", Out_q, 32'hDEADBEEF);
    @(posedge Clock);
    #1;
    check32("reassert_edge_q", Out_q, 32'h0);
    check32("reassert_out_comb", Out, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
